// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: arbiter state
// encoding, the default frame width and the index-width helper.
package uart_pkg;

  localparam int DBIT_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ISSUE  = ST_ISSUE,
    WAIT   = ST_WAIT,
    LOCKED = ST_LOCKED
  } arb_state_e;

  // Width of an index into n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: finds the first valid requester at or after the
// pointer, wrapping modulo NREQ. Purely combinational.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [IW:0] cand;
  logic        hit;

  // Scan from the farthest offset down so the nearest valid candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(NREQ)) begin
        cand = cand - (IW + 1)'(NREQ);
      end
      hit = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (cand == (IW + 1)'(i)) begin
          hit = valid[i];
        end
      end
      if (hit) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto a single UART transmitter. Packets hold
// the grant until their last byte; an owner that goes quiet for LOCK_TO
// cycles mid-packet loses the grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DBIT    = DBIT_DEF,
  parameter int LOCK_TO = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DBIT-1:0]     req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [DBIT-1:0]          tx_din,
  input  logic                     tx_done_tick,
  output logic [idx_w(NREQ)-1:0]   grant_id,
  output logic                     busy
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(LOCK_TO) + 1;

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [DBIT-1:0] data_q, data_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            owner_valid;
  logic            accept;
  logic [IW-1:0]   accept_idx;
  logic [DBIT-1:0] acc_data;
  logic            acc_last;
  logic [IW-1:0]   owner_next;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
  assign grant_id   = owner_q;
  assign tx_din     = data_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs: the accept handshake, the selected byte and the status strobes.
  always_comb begin
    owner_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) begin
        owner_valid = req_valid[i];
      end
    end

    accept     = 1'b0;
    accept_idx = owner_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          accept     = 1'b1;
          accept_idx = pick_idx;
        end
      end
      LOCKED: begin
        if (owner_valid) begin
          accept = 1'b1;
        end
      end
      default: ;
    endcase

    req_ready = '0;
    acc_data  = '0;
    acc_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (accept_idx == IW'(i));
      if (accept_idx == IW'(i)) begin
        acc_data = req_data[i*DBIT +: DBIT];
        acc_last = req_last[i];
      end
    end

    tx_start = (state_q == ISSUE);
    busy     = (state_q != IDLE);
  end

  // Next state: grant, issue, wait for the transmitter, hold or release.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    last_d   = last_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE, LOCKED: begin
        if (accept) begin
          owner_d = accept_idx;
          data_d  = acc_data;
          last_d  = acc_last;
          state_d = ISSUE;
        end else if (state_q == LOCKED) begin
          if (cnt_q == CW'(LOCK_TO - 1)) begin
            rr_ptr_d = owner_next;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done_tick) begin
          if (last_q) begin
            rr_ptr_d = owner_next;
            state_d  = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = LOCKED;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester byte queues feed the DUT,
// expected (grant, byte) pairs are popped on every tx_start, and an
// automatic responder returns tx_done_tick 20 cycles after each start.
module tb_uart_tx_arbiter;

  localparam int NREQ       = 4;
  localparam int DBIT       = 8;
  localparam int LOCK_TO    = 16;
  localparam int DONE_DELAY = 20;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DBIT-1:0] req_data = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_din;
  logic                 tx_done_tick = 1'b0;
  logic [1:0]           grant_id;
  logic                 busy;

  logic [8:0] reqQ [NREQ][$];
  logic [9:0] expQ [$];

  int         vecCount = 0;
  int         missCount = 0;
  int         doneCount = 0;
  int         lockCycles = 0;
  bit         prevStart = 1'b0;
  bit         extraDone = 1'b0;
  bit         spuriousIssue = 1'b0;
  bit         armLock = 1'b0;
  bit         lockCounting = 1'b0;
  logic [3:0] acceptMask = '0;

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .DBIT    (DBIT),
    .LOCK_TO (LOCK_TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushByte(input int id, input logic [7:0] data, input logic last);
    reqQ[id].push_back({last, data});
  endtask

  task automatic expectGrant(input logic [1:0] id, input logic [7:0] data);
    expQ.push_back({id, data});
  endtask

  function automatic bit queuesEmpty();
    bit empty = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (reqQ[i].size() != 0) empty = 1'b0;
    end
    return empty;
  endfunction

  // One clock cycle: drive requesters, sample at negedge, update after posedge.
  task automatic applyStimulus();
    logic [8:0] head;
    logic [9:0] expWord;
    for (int i = 0; i < NREQ; i++) begin
      if (reqQ[i].size() > 0) begin
        head = reqQ[i][0];
        req_valid[i] = 1'b1;
        req_data[i*DBIT +: DBIT] = head[7:0];
        req_last[i] = head[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DBIT +: DBIT] = '0;
        req_last[i] = 1'b0;
      end
    end
    if (extraDone) begin
      tx_done_tick = 1'b1;
      extraDone = 1'b0;
    end

    @(negedge clk);
    checkOutput("readyOneHot", 32'($onehot0(req_ready)), 32'd1);
    checkOutput("startRepeat", 32'(tx_start & prevStart), 32'd0);
    prevStart = tx_start;
    if (armLock) begin
      armLock = 1'b0;
      lockCounting = 1'b1;
    end else if (lockCounting) begin
      if (busy) lockCycles++;
      else lockCounting = 1'b0;
    end
    if (tx_start) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedStart", 32'd1, 32'd0);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("grantId", 32'(grant_id), 32'(expWord[9:8]));
        checkOutput("txDin", 32'(tx_din), 32'(expWord[7:0]));
      end
      doneCount = DONE_DELAY;
    end
    acceptMask = req_ready & req_valid;

    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acceptMask[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
    end
    tx_done_tick = 1'b0;
    if (doneCount > 0) begin
      doneCount--;
      if (doneCount == 0) begin
        tx_done_tick = 1'b1;
        armLock = 1'b1;
      end
    end
    if (spuriousIssue && acceptMask != 4'b0) begin
      tx_done_tick = 1'b1;
      spuriousIssue = 1'b0;
    end
  endtask

  task automatic runUntilIdle(input string tag, input int maxCycles);
    int n = 0;
    bit idleNow = 1'b0;
    while (!idleNow && n < maxCycles) begin
      applyStimulus();
      n++;
      idleNow = queuesEmpty() && expQ.size() == 0 && doneCount == 0 && !busy && !tx_done_tick;
    end
    checkOutput(tag, 32'(idleNow), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "Grant"}, 32'(grant_id), 32'd0);
    checkOutput({tag, "TxDin"}, 32'(tx_din), 32'd0);
    checkOutput({tag, "TxStart"}, 32'(tx_start), 32'd0);
    checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "Ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkResetValues("reset");

    // Two single-byte requesters alternate: 0, 2, 0, 2.
    pushByte(0, 8'h11, 1'b1); pushByte(0, 8'h12, 1'b1);
    pushByte(2, 8'h21, 1'b1); pushByte(2, 8'h22, 1'b1);
    expectGrant(2'd0, 8'h11); expectGrant(2'd2, 8'h21);
    expectGrant(2'd0, 8'h12); expectGrant(2'd2, 8'h22);
    runUntilIdle("altDrain", 300);
    checkOutput("txDinHold", 32'(tx_din), 32'h22);
    checkOutput("grantHold", 32'(grant_id), 32'd2);

    // Done tick while idle changes nothing.
    extraDone = 1'b1;
    applyStimulus();
    checkOutput("idleDoneBusy", 32'(busy), 32'd0);
    checkOutput("idleDoneReady", 32'(req_ready), 32'd0);
    applyStimulus();
    checkOutput("idleDoneBusy2", 32'(busy), 32'd0);

    // Done tick during ISSUE is ignored; the block still waits for the real one.
    pushByte(1, 8'h5a, 1'b1);
    expectGrant(2'd1, 8'h5a);
    spuriousIssue = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("issueDoneWait", 32'(busy), 32'd1);
    runUntilIdle("issueDrain", 100);

    // Move the pointer to 1 with a single byte from requester 0.
    pushByte(0, 8'h55, 1'b1);
    expectGrant(2'd0, 8'h55);
    runUntilIdle("ptrDrain", 100);

    // Packet from 1 holds the grant while 0 and 3 wait.
    pushByte(0, 8'h0c, 1'b1);
    pushByte(1, 8'h1a, 1'b0); pushByte(1, 8'h1b, 1'b0); pushByte(1, 8'h1c, 1'b1);
    pushByte(3, 8'h3d, 1'b1);
    expectGrant(2'd1, 8'h1a); expectGrant(2'd1, 8'h1b); expectGrant(2'd1, 8'h1c);
    expectGrant(2'd3, 8'h3d); expectGrant(2'd0, 8'h0c);
    runUntilIdle("packetDrain", 400);

    // Requester 2 stalls mid-packet and loses the grant after LOCK_TO cycles.
    lockCycles = 0;
    pushByte(2, 8'h2a, 1'b0);
    expectGrant(2'd2, 8'h2a);
    runUntilIdle("lockDrain", 200);
    checkOutput("lockCycles", 32'(lockCycles), 32'd16);
    pushByte(2, 8'h77, 1'b1);
    pushByte(3, 8'h33, 1'b1);
    expectGrant(2'd3, 8'h33); expectGrant(2'd2, 8'h77);
    runUntilIdle("releaseDrain", 200);

    // Reset during WAIT, then the late done tick must be ignored.
    pushByte(3, 8'h99, 1'b1);
    expectGrant(2'd3, 8'h99);
    n = 0;
    while (expQ.size() != 0 && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput("resetStartSeen", 32'(expQ.size()), 32'd0);
    repeat (5) applyStimulus();
    checkOutput("inWait", 32'(busy), 32'd1);
    reset_n = 1'b0;
    applyStimulus();
    reset_n = 1'b1;
    checkResetValues("midReset");
    for (int k = 0; k < 20; k++) begin
      applyStimulus();
      checkOutput("postResetReady", 32'(req_ready), 32'd0);
      checkOutput("postResetBusy", 32'(busy), 32'd0);
    end
    checkOutput("lateDoneFired", 32'(doneCount), 32'd0);
    pushByte(1, 8'h41, 1'b1);
    pushByte(3, 8'h43, 1'b1);
    expectGrant(2'd1, 8'h41); expectGrant(2'd3, 8'h43);
    runUntilIdle("postResetDrain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
